i_cache: RTL and testbench

- Direct-mapped, read-only instruction cache in the Fetch stage, between the PC register and the 16-word-line instruction memory.
- Looks up the fetch PC combinationally and reports a hit.
- On a hit it returns the addressed 32-bit instruction.
- On a miss it waits for the memory's ready pulse and writes the whole 512-bit line.

---
 rtl/i_cache_if.sv | 34 +++
 rtl/i_cache.sv | 104 ++++++++++
 tb/tb_i_cache.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/i_cache_if.sv
// Fetch-side bus of the instruction cache: PC, Decode redirect, memory line return and lookup
// results. The master (fetch/memory side) drives the requests; the slave (the cache) answers.
interface i_cache_if;
    logic [31:0]  pcF;
    logic         pcsrcD;
    logic         jumpD;
    logic [1:0]   branchD;
    logic [511:0] instr_memory_RD;
    logic         instr_memory_ready;
    logic         hit;
    logic [31:0]  instrF;

    modport master (
        output pcF,
        output pcsrcD,
        output jumpD,
        output branchD,
        output instr_memory_RD,
        output instr_memory_ready,
        input  hit,
        input  instrF
    );

    modport slave (
        input  pcF,
        input  pcsrcD,
        input  jumpD,
        input  branchD,
        input  instr_memory_RD,
        input  instr_memory_ready,
        output hit,
        output instrF
    );
endinterface

// File: rtl/i_cache.sv
// Direct-mapped read-only instruction cache with combinational lookup and whole-line fill.
// Optional hit/fill counters are built when ICACHE_STATS_EN is defined.
module i_cache #(
    parameter int unsigned NUM_LINES  = 8,
    parameter int unsigned LINE_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
`ifdef ICACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_fill_count,
`endif
    i_cache_if.slave    fetch_io
);

    localparam int unsigned IDX_W  = $clog2(NUM_LINES);
    localparam int unsigned TAG_W  = 32 - 6 - IDX_W;
    localparam int unsigned LINE_W = LINE_WORDS * 32;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [3:0]        wsel;
    logic              redirect;
    logic              fill;
    logic [LINE_W-1:0] line;
    logic              unused_byte_off;

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign wsel            = fetch_io.pcF[5:2];
    assign idx             = fetch_io.pcF[6 +: IDX_W];
    assign tag             = fetch_io.pcF[31 -: TAG_W];
    assign unused_byte_off = ^fetch_io.pcF[1:0];

    assign redirect = fetch_io.pcsrcD | fetch_io.jumpD | (fetch_io.branchD != 2'b00);

    assign fetch_io.hit = valid_q[idx] && (tag_q[idx] == tag);
    assign line         = data_q[idx];

    // Stale ready pulses (line already present) and pulses during a redirect are dropped.
    assign fill = fetch_io.instr_memory_ready & ~fetch_io.hit & ~redirect;

    always_comb begin
        fetch_io.instrF = 32'h0000_0000;
        if (fetch_io.hit) begin
            fetch_io.instrF = line[{wsel, 5'd0} +: 32];
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (fill) begin
            valid_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data need no reset; they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (fill && reset) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= fetch_io.instr_memory_RD;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] fill_count_q, fill_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        fill_count_d = fill_count_q;
        if (fetch_io.hit) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (fill) begin
            fill_count_d = fill_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count_q  <= '0;
            fill_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            fill_count_q <= fill_count_d;
        end
    end

    assign hit_count       = hit_count_q;
    assign miss_fill_count = fill_count_q;
`endif

endmodule

// File: tb/tb_i_cache.sv
// Self-checking bench for i_cache: a reference model predicts each lookup, expectations go
// through a scoreboard queue and are compared when the outputs are sampled.
module tb_i_cache;

    localparam int unsigned NumLines = 8;

    typedef struct packed {
        logic        hit;
        logic [31:0] instr;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    logic          m_valid [NumLines];
    logic [22:0]   m_tag   [NumLines];
    logic [511:0]  m_data  [NumLines];
    int unsigned   exp_hits  = 0;
    int unsigned   exp_fills = 0;
    logic          m_h;
    logic [2:0]    m_ix;

    always #5 clk = ~clk;

    i_cache_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_fill_count;
`endif

    i_cache #(.NUM_LINES(NumLines), .LINE_WORDS(16)) dut (
        .clk             (clk),
        .reset           (reset),
`ifdef ICACHE_STATS_EN
        .hit_count       (hit_count),
        .miss_fill_count (miss_fill_count),
`endif
        .fetch_io        (bus)
    );

    function automatic logic m_hit(input logic [31:0] pc);
        return m_valid[pc[8:6]] && (m_tag[pc[8:6]] == pc[31:9]);
    endfunction

    // Reference model, driven only by bench-side stimulus.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NumLines; i++) m_valid[i] = 1'b0;
            exp_hits  = 0;
            exp_fills = 0;
        end else begin
            m_h  = m_hit(bus.pcF);
            m_ix = bus.pcF[8:6];
            if (m_h) exp_hits++;
            if (bus.instr_memory_ready && !m_h && !bus.pcsrcD && !bus.jumpD &&
                bus.branchD == 2'b00) begin
                m_valid[m_ix] = 1'b1;
                m_tag[m_ix]   = bus.pcF[31:9];
                m_data[m_ix]  = bus.instr_memory_RD;
                exp_fills++;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic expect_now();
        exp_t e;
        e.hit   = m_hit(bus.pcF);
        e.instr = e.hit ? m_data[bus.pcF[8:6]][{bus.pcF[5:2], 5'd0} +: 32] : 32'h0;
        sb.push_back(e);
    endtask

    task automatic observe(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq({tag, "_hit"}, {31'd0, bus.hit}, {31'd0, e.hit});
            check_eq({tag, "_instr"}, bus.instrF, e.instr);
        end
    endtask

    task automatic lookup(input logic [31:0] pc, input string tag);
        @(negedge clk);
        bus.pcF = pc;
        expect_now();
        #1;
        observe(tag);
    endtask

    // redir: 0 none, 1 branchD, 2 pcsrcD, 3 jumpD
    task automatic fill(input logic [31:0] pc, input logic [31:0] base, input int redir);
        @(negedge clk);
        bus.pcF = pc;
        for (int k = 0; k < 16; k++) bus.instr_memory_RD[32*k +: 32] = base + k;
        bus.instr_memory_ready = 1'b1;
        case (redir)
            1: bus.branchD = 2'b01;
            2: bus.pcsrcD  = 1'b1;
            3: bus.jumpD   = 1'b1;
            default: ;
        endcase
        @(negedge clk);
        bus.instr_memory_ready = 1'b0;
        bus.branchD = 2'b00;
        bus.pcsrcD  = 1'b0;
        bus.jumpD   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NumLines; i++) m_valid[i] = 1'b0;
        bus.pcF = 32'h0;
        bus.pcsrcD = 1'b0;
        bus.jumpD = 1'b0;
        bus.branchD = 2'b00;
        bus.instr_memory_RD = '0;
        bus.instr_memory_ready = 1'b0;

        lookup(32'h0, "in_reset");
        @(negedge clk);
        reset = 1'b1;

        // Test 1: cold miss then fill
        lookup(32'h0, "t1_cold");
        check_eq("t1_cold_const", {31'd0, bus.hit}, 32'd0);
        fill(32'h0, 32'h1000_0000, 0);
        lookup(32'h0, "t1_hit");
        check_eq("t1_instr_const", bus.instrF, 32'h1000_0000);

        // Test 2: last word, byte offset ignored, neighbouring index
        lookup(32'h3C, "t2_w15");
        check_eq("t2_w15_const", bus.instrF, 32'h1000_000F);
        lookup(32'h3E, "t2_boff");
        lookup(32'h40, "t2_idx1");

        // Stale ready while hitting must not overwrite
        fill(32'h0, 32'hDEAD_0000, 0);
        lookup(32'h8, "stale");
        check_eq("stale_const", bus.instrF, 32'h1000_0002);

        // Test 3: conflicting tag evicts
        lookup(32'h200, "t3_miss");
        fill(32'h200, 32'h2000_0000, 0);
        lookup(32'h200, "t3_hit");
        check_eq("t3_instr_const", bus.instrF, 32'h2000_0000);
        lookup(32'h0, "t3_evicted");
        lookup(32'h204, "t3_w1");

        // Test 4: ready during each redirect kind is dropped
        lookup(32'h80, "t4_miss");
        for (int r = 1; r <= 3; r++) begin
            fill(32'h80, 32'h3000_0000 + 32'(r << 8), r);
            lookup(32'h80, $sformatf("t4_redir%0d", r));
        end
        fill(32'h80, 32'h3000_0000, 0);
        lookup(32'h88, "t4_fill");
        check_eq("t4_instr_const", bus.instrF, 32'h3000_0002);

        // Top index and aliasing line
        fill(32'h1C0, 32'h4000_0000, 0);
        lookup(32'h1D4, "wrap_hit");
        lookup(32'h3C0, "wrap_alias");
        fill(32'h3C0, 32'h5000_0000, 0);
        lookup(32'h3C4, "wrap_refill");
        lookup(32'h1C0, "wrap_evicted");

        // Test 5: async reset mid-cycle, fill attempt while held in reset
        lookup(32'h200, "t5_pre");
        #2;
        reset = 1'b0;
        #1;
        expect_now();
        observe("t5_async");
        check_eq("t5_async_const", {31'd0, bus.hit}, 32'd0);
        fill(32'h40, 32'h6000_0000, 0);
        @(negedge clk);
        reset = 1'b1;
        lookup(32'h0, "t5_after0");
        lookup(32'h200, "t5_after200");
        lookup(32'h40, "t5_nofill");
        fill(32'h40, 32'h6000_0000, 0);
        lookup(32'h40, "t5_refill");
        lookup(32'h40, "t5_stall");

`ifdef ICACHE_STATS_EN
        @(negedge clk);
        check_eq("stats_hits", hit_count, exp_hits);
        check_eq("stats_fills", miss_fill_count, exp_fills);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
